// File: rtl/div_hilo_capture.sv
// rtl/div_hilo_capture.sv - operand sequencing, settle wait and HI/LO writeback around a combinational divider
// Zero divisors bypass the settle wait and never capture the divider output.
module div_hilo_capture #(
   parameter int SETTLE_CYCLES = 4,
   parameter int WIDTH         = 32
) (
   input  logic               clock,
   input  logic               clear,
   input  logic               start,
   input  logic [WIDTH-1:0]   a_in,
   input  logic [WIDTH-1:0]   b_in,
   output logic [WIDTH-1:0]   a_out,
   output logic [WIDTH-1:0]   b_out,
   input  logic [2*WIDTH-1:0] div_result,
   input  logic               hi_we,
   input  logic               lo_we,
   input  logic [WIDTH-1:0]   wdata,
   output logic [WIDTH-1:0]   hi_out,
   output logic [WIDTH-1:0]   lo_out,
   output logic               busy,
   output logic               done,
   output logic               div_zero
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      ZERO   = 2'd2
   } state_t;

   localparam logic [7:0] COUNT_INIT = 8'(SETTLE_CYCLES - 1);

   state_t           state, state_nxt;
   logic [7:0]       count, count_nxt;
   logic [WIDTH-1:0] a_nxt, b_nxt, hi_nxt, lo_nxt;
   logic             busy_nxt, done_nxt, div_zero_nxt;

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state    <= IDLE;
         count    <= '0;
         a_out    <= '0;
         b_out    <= '0;
         hi_out   <= '0;
         lo_out   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         state    <= state_nxt;
         count    <= count_nxt;
         a_out    <= a_nxt;
         b_out    <= b_nxt;
         hi_out   <= hi_nxt;
         lo_out   <= lo_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
         div_zero <= div_zero_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      count_nxt    = count;
      a_nxt        = a_out;
      b_nxt        = b_out;
      busy_nxt     = busy;
      done_nxt     = 1'b0;
      div_zero_nxt = div_zero;
      // Direct writes apply in every state unless the settle capture overrides them below.
      hi_nxt       = hi_we ? wdata : hi_out;
      lo_nxt       = lo_we ? wdata : lo_out;

      case (state)
         IDLE: begin
            if (start) begin
               a_nxt        = a_in;
               b_nxt        = b_in;
               div_zero_nxt = 1'b0;
               count_nxt    = COUNT_INIT;
               if (b_in == '0) begin
                  state_nxt = ZERO;
                  busy_nxt  = 1'b0;
               end else begin
                  state_nxt = SETTLE;
                  busy_nxt  = 1'b1;
               end
            end
         end
         SETTLE: begin
            if (count != 8'd0) begin
               count_nxt = count - 8'd1;
            end else begin
               hi_nxt    = div_result[2*WIDTH-1:WIDTH];
               lo_nxt    = div_result[WIDTH-1:0];
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end
         end
         ZERO: begin
            div_zero_nxt = 1'b1;
            done_nxt     = 1'b1;
            state_nxt    = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_div_hilo_capture.sv
// tb/tb_div_hilo_capture.sv - scoreboard bench for div_hilo_capture with a behavioural divider stub
module tb_div_hilo_capture;

   localparam int S = 4;
   localparam int W = 32;

   logic           clock = 1'b0;
   logic           clear = 1'b0;
   logic           start = 1'b0;
   logic [W-1:0]   a_in = '0, b_in = '0, wdata = '0;
   logic           hi_we = 1'b0, lo_we = 1'b0;
   logic [W-1:0]   a_out, b_out, hi_out, lo_out;
   logic [2*W-1:0] div_result;
   logic           busy, done, div_zero;

   int checks = 0;
   int errors = 0;
   int done_seen = 0;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
   } exp_t;
   exp_t exp_q[$];

   always #5 clock = ~clock;

   // Stand-in divider: garbage on zero divisor so an illegal capture would show.
   assign div_result = (b_out == '0) ? 64'hBADC0DE0_BADC0DE0 : {a_out % b_out, a_out / b_out};

   div_hilo_capture #(.SETTLE_CYCLES(S), .WIDTH(W)) dut (
      .clock(clock), .clear(clear), .start(start), .a_in(a_in), .b_in(b_in),
      .a_out(a_out), .b_out(b_out), .div_result(div_result),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done), .div_zero(div_zero)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (clear && done) begin
            done_seen++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 expected no pending operation");
            end else begin
               e = exp_q.pop_front();
               chk("sb_hi", 64'(hi_out), 64'(e.hi));
               chk("sb_lo", 64'(lo_out), 64'(e.lo));
               chk("sb_div_zero", 64'(div_zero), 64'(e.dz));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
      a_in  = a;
      b_in  = b;
      start = 1'b1;
   endtask

   // Call at the negedge where start is driven; returns negedges until done.
   task automatic wait_done(input int inj_start_at, input int inj_we_at,
                            output int bcnt, output int lat);
      bcnt = 0;
      lat  = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clock);
         start = (i == inj_start_at);
         if (i == inj_start_at) a_in = 32'd9;
         hi_we = (i == inj_we_at);
         if (i == inj_we_at) wdata = 32'hDEADBEEF;
         if (busy) bcnt++;
         if (done) begin
            lat = i;
            break;
         end
      end
      start = 1'b0;
      hi_we = 1'b0;
      if (lat == 0) chk("done_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      int bcnt, lat, lat2, d0;

      @(negedge clock);
      chk("rst_a_out", 64'(a_out), 64'd0);
      chk("rst_hi", 64'(hi_out), 64'd0);
      chk("rst_flags", {61'd0, busy, done, div_zero}, 64'd0);
      clear = 1'b1;
      @(negedge clock);

      // Normal divide with an ignored mid-settle start.
      exp_q.push_back('{hi: 32'h2, lo: 32'hE, dz: 1'b0});
      d0 = done_seen;
      issue(32'd100, 32'd7);
      wait_done(2, 0, bcnt, lat);
      chk("norm_busy_cycles", 64'(bcnt), 64'(S));
      chk("norm_latency", 64'(lat), 64'(S + 1));
      chk("ignored_start_a_out", 64'(a_out), 64'd100);
      @(negedge clock);
      chk("norm_done_once", 64'(done_seen - d0), 64'd1);
      chk("done_one_cycle", 64'(done), 64'd0);
      chk("hold_b_out", 64'(b_out), 64'd7);

      // Capture beats a same-edge hi_we.
      exp_q.push_back('{hi: 32'h4, lo: 32'h1C, dz: 1'b0});
      issue(32'd200, 32'd7);
      wait_done(0, S, bcnt, lat);
      @(negedge clock);
      hi_we = 1'b1;
      wdata = 32'hDEADBEEF;
      @(negedge clock);
      hi_we = 1'b0;
      chk("idle_hi_we", 64'(hi_out), 64'hDEADBEEF);
      chk("idle_lo_kept", 64'(lo_out), 64'h1C);

      // Preload both registers, then divide by zero.
      hi_we = 1'b1;
      lo_we = 1'b1;
      wdata = 32'hAAAAAAAA;
      @(negedge clock);
      lo_we = 1'b1;
      hi_we = 1'b0;
      wdata = 32'h55555555;
      @(negedge clock);
      lo_we = 1'b0;
      chk("preload_hi", 64'(hi_out), 64'hAAAAAAAA);
      chk("preload_lo", 64'(lo_out), 64'h55555555);
      exp_q.push_back('{hi: 32'hAAAAAAAA, lo: 32'h55555555, dz: 1'b1});
      issue(32'd55, 32'd0);
      wait_done(0, 0, bcnt, lat);
      chk("zero_latency", 64'(lat), 64'd2);
      chk("zero_busy_never", 64'(bcnt), 64'd0);
      @(negedge clock);
      chk("div_zero_held", 64'(div_zero), 64'd1);

      // Back-to-back: second start issued in the done cycle.
      exp_q.push_back('{hi: 32'h1, lo: 32'h21, dz: 1'b0});
      issue(32'd100, 32'd3);
      wait_done(0, 0, bcnt, lat);
      chk("div_zero_cleared", 64'(div_zero), 64'd0);
      exp_q.push_back('{hi: 32'h2, lo: 32'h10, dz: 1'b0});
      issue(32'd50, 32'd3);
      wait_done(0, 0, bcnt, lat2);
      chk("b2b_spacing", 64'(lat2), 64'(S + 1));
      @(negedge clock);

      // Reset in the middle of settle aborts the operation.
      d0 = done_seen;
      issue(32'd100, 32'd7);
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      #3 clear = 1'b0;
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_regs", {a_out, b_out} | {hi_out, lo_out}, 64'd0);
      chk("abort_flags", {62'd0, done, div_zero}, 64'd0);
      @(negedge clock);
      clear = 1'b1;
      repeat (10) @(negedge clock);
      chk("abort_no_done", 64'(done_seen - d0), 64'd0);
      chk("abort_hi_kept", 64'(hi_out), 64'd0);
      chk("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
